// File: rtl/fifo_axi_wr_ctrl_pkg.sv
// Shared types and constants for the byte-FIFO to AXI-Lite write controller.
package fifo_axi_wr_ctrl_pkg;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned StrbWidth = WordWidth / 8;
  localparam int unsigned IdxWidth  = 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StResp
  } state_e;

  // Strobe for a partially packed word holding idx bytes from lane 0 upward.
  function automatic logic [StrbWidth-1:0] partial_strb(input logic [IdxWidth-1:0] idx);
    logic [StrbWidth-1:0] strb;
    case (idx)
      2'd1:    strb = 4'h1;
      2'd2:    strb = 4'h3;
      2'd3:    strb = 4'h7;
      default: strb = 4'h0;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/fifo_axi_wr_ctrl_if.sv
// AXI-Lite write channels (AW, W, B) between the controller and its slave.
interface fifo_axi_wr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import fifo_axi_wr_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [WordWidth-1:0]  wdata;
  logic [StrbWidth-1:0]  wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/fifo_axi_wr_ctrl_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; owns lane register, byte index and strobe.
module fifo_axi_wr_ctrl_byte_packer
  import fifo_axi_wr_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_i,
  input  logic [7:0]           data_i,
  input  logic                 flush_i,
  input  logic                 clear_i,
  output logic [WordWidth-1:0] word_o,
  output logic [StrbWidth-1:0] strb_o,
  output logic [IdxWidth-1:0]  byte_idx_o
);

  logic [WordWidth-1:0] word_d, word_q;
  logic [StrbWidth-1:0] strb_d, strb_q;
  logic [IdxWidth-1:0]  idx_d, idx_q;

  always_comb begin
    word_d = word_q;
    strb_d = strb_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      strb_d = '0;
      idx_d  = '0;
    end else begin
      if (cap_i) begin
        word_d[{idx_q, 3'b000} +: 8] = data_i;
        // A full word keeps idx at 3 until the write completes and clears it.
        if (idx_q == 2'd3) begin
          strb_d = '1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      if (flush_i) begin
        strb_d = partial_strb(idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
      strb_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      strb_q <= strb_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o     = word_q;
  assign strb_o     = strb_q;
  assign byte_idx_o = idx_q;

endmodule

// File: rtl/fifo_axi_wr_ctrl.sv
// Drains a byte FIFO, packs bytes into words and writes them over AXI-Lite at rising addresses.
module fifo_axi_wr_ctrl
  import fifo_axi_wr_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [7:0]              fifo_data,
  input  logic                    flush,
  fifo_axi_wr_ctrl_if.master      axi,
  output logic                    busy,
  output logic                    err
);

  state_e                state_d, state_q;
  logic                  rd_en_d, rd_en_q;
  logic                  awvalid_d, awvalid_q;
  logic                  wvalid_d, wvalid_q;
  logic                  bready_d, bready_q;
  logic                  busy_d, busy_q;
  logic                  err_d, err_q;
  logic [ADDR_WIDTH-1:0] awaddr_d, awaddr_q;

  logic                  cap, load_strb, clear;
  logic [WordWidth-1:0]  word;
  logic [StrbWidth-1:0]  strb;
  logic [IdxWidth-1:0]   byte_idx;

  fifo_axi_wr_ctrl_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (cap),
    .data_i     (fifo_data),
    .flush_i    (load_strb),
    .clear_i    (clear),
    .word_o     (word),
    .strb_o     (strb),
    .byte_idx_o (byte_idx)
  );

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    err_d     = err_q;
    cap       = 1'b0;
    load_strb = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StRd;
          rd_en_d = 1'b1;
        end else if (flush && (byte_idx != '0)) begin
          state_d   = StWr;
          load_strb = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        cap = 1'b1;
        if (byte_idx == 2'd3) begin
          state_d   = StWr;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StWr: begin
        if (axi.awready) awvalid_d = 1'b0;
        if (axi.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = StResp;
          bready_d = 1'b1;
        end
      end
      StResp: begin
        if (axi.bvalid) begin
          state_d  = StIdle;
          bready_d = 1'b0;
          // Address advances even on an error response; no retry is attempted.
          awaddr_d = awaddr_q + ADDR_WIDTH'(4);
          clear    = 1'b1;
          if (axi.bresp != RespOkay) err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= BASE_ADDR;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = word;
  assign axi.wstrb   = strb;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fifo_axi_wr_ctrl.sv
// Scoreboard bench: stimulus queues expected writes, a slave-side monitor pops and compares.
module tb_fifo_axi_wr_ctrl;
  import fifo_axi_wr_ctrl_pkg::*;

  localparam logic [31:0] Base = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- main DUT (32-bit address) ----------------
  fifo_axi_wr_ctrl_if #(.ADDR_WIDTH(32)) axi ();
  logic [7:0] fq[$];
  logic       fifo_empty, fifo_rd_en, flush, busy, err;
  logic [7:0] fifo_data = 8'h00;
  assign fifo_empty = (fq.size() == 0);

  fifo_axi_wr_ctrl #(.ADDR_WIDTH(32), .BASE_ADDR(Base)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .axi        (axi),
    .busy       (busy),
    .err        (err)
  );

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data <= fq[0];
      fq.pop_front();
    end
  end

  // ---------------- small DUT (4-bit address, wraps) ----------------
  fifo_axi_wr_ctrl_if #(.ADDR_WIDTH(4)) axi_s ();
  logic [7:0] fq2[$];
  logic       fifo2_empty, fifo2_rd_en, busy2, err2;
  logic [7:0] fifo2_data = 8'h00;
  assign fifo2_empty = (fq2.size() == 0);

  fifo_axi_wr_ctrl #(.ADDR_WIDTH(4), .BASE_ADDR(4'hC)) u_dut_small (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo2_empty),
    .fifo_rd_en (fifo2_rd_en),
    .fifo_data  (fifo2_data),
    .flush      (1'b0),
    .axi        (axi_s),
    .busy       (busy2),
    .err        (err2)
  );

  always @(posedge clk) begin
    if (fifo2_rd_en && fq2.size() > 0) begin
      fifo2_data <= fq2[0];
      fq2.pop_front();
    end
  end

  // ---------------- scoreboard and slave for main DUT ----------------
  wr_t        exp_q[$];
  logic [1:0] bresp_q[$];
  int         aw_delay = 0, w_delay = 0, b_delay = 0;
  int         aw_cnt, w_cnt, b_cnt;
  logic       aw_done, w_done, pair_done;
  logic [31:0] aw_first, aw_cap, w_first, w_cap;
  logic [3:0]  ws_first, ws_cap;

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      aw_done = 1'b0; w_done = 1'b0; pair_done = 1'b0;
    end else begin
      if (fifo_rd_en) chk("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (axi.awready) begin
        axi.awready = 1'b0;
        aw_done = 1'b1;
        chk("aw_stable", aw_cap, aw_first);
      end else if (axi.awvalid) begin
        if (aw_done) chk("aw_overlap", 32'd1, 32'd0);
        if (aw_cnt == 0) aw_first = axi.awaddr;
        if (aw_cnt == aw_delay) begin
          axi.awready = 1'b1;
          aw_cap = axi.awaddr;
        end
        aw_cnt++;
      end
      if (axi.wready) begin
        axi.wready = 1'b0;
        w_done = 1'b1;
        chk("w_stable", {w_cap[31:4], w_cap[3:0] ^ ws_cap}, {w_first[31:4], w_first[3:0] ^ ws_first});
      end else if (axi.wvalid) begin
        if (w_done) chk("w_overlap", 32'd1, 32'd0);
        if (w_cnt == 0) begin
          w_first = axi.wdata; ws_first = axi.wstrb;
        end
        if (w_cnt == w_delay) begin
          axi.wready = 1'b1;
          w_cap = axi.wdata; ws_cap = axi.wstrb;
        end
        w_cnt++;
      end
      if (aw_done && w_done && !pair_done) begin
        pair_done = 1'b1;
        b_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("awaddr", aw_cap, e.addr);
          chk("wdata", w_cap, e.data);
          chk("wstrb", {28'd0, ws_cap}, {28'd0, e.strb});
        end
      end
      if (axi.bvalid) begin
        axi.bvalid = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; pair_done = 1'b0;
        aw_cnt = 0; w_cnt = 0;
      end else if (pair_done && axi.bready) begin
        if (b_cnt == b_delay) begin
          axi.bvalid = 1'b1;
          axi.bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : RespOkay;
        end
        b_cnt++;
      end
    end
  end

  // ---------------- always-ready slave and monitor for small DUT ----------------
  logic [3:0]  exp2_addr[$];
  logic [31:0] exp2_data[$];

  initial begin
    axi_s.awready = 1'b0;
    axi_s.wready  = 1'b0;
    axi_s.bvalid  = 1'b0;
    axi_s.bresp   = 2'b00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      axi_s.awready = 1'b0; axi_s.wready = 1'b0; axi_s.bvalid = 1'b0;
    end else begin
      if (axi_s.awvalid && !axi_s.awready) begin
        if (exp2_addr.size() == 0) chk("small_unexpected_aw", 32'd1, 32'd0);
        else chk("small_awaddr", {28'd0, axi_s.awaddr}, {28'd0, exp2_addr.pop_front()});
        axi_s.awready = 1'b1;
      end else begin
        axi_s.awready = 1'b0;
      end
      if (axi_s.wvalid && !axi_s.wready) begin
        if (exp2_data.size() == 0) chk("small_unexpected_w", 32'd1, 32'd0);
        else chk("small_wdata", axi_s.wdata, exp2_data.pop_front());
        axi_s.wready = 1'b1;
      end else begin
        axi_s.wready = 1'b0;
      end
      axi_s.bvalid = axi_s.bready && !axi_s.bvalid;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] exp_addr;

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) fq.push_back(w[8*i +: 8]);
    exp_q.push_back('{addr: exp_addr, data: w, strb: 4'hF});
    exp_addr += 32'd4;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && fq.size() == 0 && exp_q.size() == 0 && !axi.awvalid) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awaddr"}, axi.awaddr, Base);
    chk({tag, "_wdata"}, axi.wdata, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, axi.wstrb}, 32'd0);
    chk({tag, "_ctl"}, {26'd0, busy, err, axi.awvalid, axi.wvalid, axi.bready, fifo_rd_en},
        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    flush = 1'b0;
    exp_addr = Base;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Four bytes make one full word.
    push_word(32'h4433_2211);
    wait_idle("idle_full_word");

    // AW accepted three cycles after W, two back-to-back words.
    aw_delay = 3;
    push_word(32'h0403_0201);
    push_word(32'h0807_0605);
    wait_idle("idle_aw_delay");
    aw_delay = 0;

    // Partial words via flush: 2, 3 and 1 bytes.
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    wait_idle("idle_before_flush2");
    exp_q.push_back('{addr: exp_addr, data: 32'h0000_BBAA, strb: 4'h3});
    exp_addr += 32'd4;
    pulse_flush();
    wait_idle("idle_flush2");
    push_word(32'hC4C3_C2C1);
    wait_idle("idle_after_flush2");
    fq.push_back(8'h05); fq.push_back(8'h06); fq.push_back(8'h07);
    wait_idle("idle_before_flush3");
    exp_q.push_back('{addr: exp_addr, data: 32'h0007_0605, strb: 4'h7});
    exp_addr += 32'd4;
    pulse_flush();
    wait_idle("idle_flush3");
    fq.push_back(8'h09);
    wait_idle("idle_before_flush1");
    exp_q.push_back('{addr: exp_addr, data: 32'h0000_0009, strb: 4'h1});
    exp_addr += 32'd4;
    pulse_flush();
    wait_idle("idle_flush1");

    // Flush with nothing packed must not start a write.
    pulse_flush();
    repeat (6) @(negedge clk);
    chk("flush_empty_ignored", {31'd0, busy}, 32'd0);

    // Error response on first of two writes; sticky, address still advances.
    chk("err_before", {31'd0, err}, 32'd0);
    bresp_q.push_back(RespSlvErr);
    push_word(32'h1413_1211);
    push_word(32'h1817_1615);
    wait_idle("idle_err");
    chk("err_set", {31'd0, err}, 32'd1);
    push_word(32'h2423_2221);
    wait_idle("idle_err_after");
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset while waiting for the response abandons the write.
    b_delay = 30;
    push_word(32'h3433_3231);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (axi.bready) done = 1'b1;
    end
    chk("reach_resp", {31'd0, done}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b1;
    b_delay = 0;
    exp_q.delete();
    exp_addr = Base;
    @(negedge clk);
    push_word(32'h4443_4241);
    wait_idle("idle_after_reset");

    // Narrow address wraps 0xC -> 0x0.
    for (int i = 0; i < 8; i++) fq2.push_back(8'h10 + 8'(i));
    exp2_addr.push_back(4'hC); exp2_data.push_back(32'h1312_1110);
    exp2_addr.push_back(4'h0); exp2_data.push_back(32'h1716_1514);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy2 && fq2.size() == 0 && exp2_addr.size() == 0 && exp2_data.size() == 0)
        done = 1'b1;
    end
    chk("idle_small_wrap", {31'd0, done}, 32'd1);
    chk("small_err", {31'd0, err2}, 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
